// File: rtl/cascade_counter_pkg.sv
// Shared limits and direction encoding for the cascaded up/down counter.
package cascade_counter_pkg;

    localparam int RADIX_MIN  = 2;
    localparam int RADIX_MAX  = 16;
    localparam int DIGITS_MAX = 8;

    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

endpackage : cascade_counter_pkg

// File: rtl/counter_digit.sv
// One modulo-RADIX digit register with load clamp and step-driven up/down count.
module counter_digit
    import cascade_counter_pkg::*;
#(
    parameter  int RADIX = 10,
    localparam int DW    = $clog2(RADIX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_digit,
    input  logic          step,
    input  logic          updown,
    output logic [DW-1:0] digit,
    output logic          at_max,
    output logic          at_min
);

    localparam logic [DW-1:0] DIGIT_MAX = DW'(RADIX - 1);

    logic [DW-1:0] digit_q, digit_d;

    assign at_max = (digit_q == DIGIT_MAX);
    assign at_min = (digit_q == '0);
    assign digit  = digit_q;

    always_comb begin
        // NOTE: default first so every path assigns digit_d and no latch is inferred.
        digit_d = digit_q;
        if (load) begin
            digit_d = (load_digit > DIGIT_MAX) ? DIGIT_MAX : load_digit;
        end else if (step) begin
            if (updown == CNT_UP) begin
                digit_d = at_max ? '0 : digit_q + DW'(1);
            end else begin
                digit_d = at_min ? DIGIT_MAX : digit_q - DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every digit samples pre-edge state of its neighbours.
        if (rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule : counter_digit

// File: rtl/cascade_updown_counter.sv
// Multi-digit modulo-RADIX up/down counter with load, terminal count and wrap pulse.
// Optional sticky overflow output enabled by CASCADE_UPDOWN_COUNTER_STICKY_OVF_EN.
module cascade_updown_counter
    import cascade_counter_pkg::*;
#(
    parameter  int RADIX  = 10,
    parameter  int DIGITS = 2,
    localparam int DW     = $clog2(RADIX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 updown,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] load_val,
    output logic [DIGITS*DW-1:0] count,
    output logic                 tc,
    output logic                 wrap
`ifdef CASCADE_UPDOWN_COUNTER_STICKY_OVF_EN
    ,
    output logic                 ovf
`endif
);

    if (RADIX < RADIX_MIN || RADIX > RADIX_MAX || DIGITS < 1 || DIGITS > DIGITS_MAX) begin : g_param_check
        $error("cascade_updown_counter: RADIX=%0d DIGITS=%0d out of range", RADIX, DIGITS);
    end

    logic              run;
    logic [DIGITS-1:0] step, at_max, at_min, advance;
    logic              wrap_q, wrap_d;

    assign run = en & ~load;

    // A digit steps when every lower digit sits at its rollover value for this direction.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign advance[i] = (updown == CNT_UP) ? at_max[i] : at_min[i];

        if (i == 0) begin : g_lsd
            assign step[i] = run;
        end else begin : g_upper
            assign step[i] = run & (&advance[i-1:0]);
        end

        counter_digit #(.RADIX(RADIX)) u_digit (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .load_digit (load_val[i*DW +: DW]),
            .step       (step[i]),
            .updown     (updown),
            .digit      (count[i*DW +: DW]),
            .at_max     (at_max[i]),
            .at_min     (at_min[i])
        );
    end

    assign tc     = run & (&advance);
    assign wrap_d = tc;
    assign wrap   = wrap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

`ifdef CASCADE_UPDOWN_COUNTER_STICKY_OVF_EN
    logic ovf_q, ovf_d;

    assign ovf_d = load ? 1'b0 : (ovf_q | tc);
    assign ovf   = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule : cascade_updown_counter
